wx_mem_responder: RTL and testbench

Memory-side responder for the compute engine's weight/activation port: holds four weight banks and four activation banks, serves combinational reads on `w_addr`/`x_addr`, and commits activation writes on the `x_wq` strobe. A host preload port fills banks before a run. A run-control FSM drives the engine's `en`, waits for `compute_finish`, then returns ownership to the host. Sits between the host/loader and the compute engine, as the other end of its memory interface.

---
 rtl/wx_mem_responder.sv | 132 +++++++++++++
 tb/tb_wx_mem_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wx_mem_responder.sv
// Memory-side responder for the compute engine: four weight and four activation banks
// with combinational reads, a host preload port and a run-control FSM for the engine.
module wx_mem_responder #(
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int W_SEL_LEN  = 2,
  parameter int X_SEL_LEN  = 2,
  parameter int W_DEPTH    = 1048576,
  parameter int X_DEPTH    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic                  ld_is_w,
  input  logic [1:0]            ld_sel,
  input  logic [W_ADDR_LEN-1:0] ld_addr,
  input  logic                  ld_data,
  output logic                  compute_en,
  input  logic                  compute_finish,
  input  logic [W_ADDR_LEN-1:0] w_addr,
  input  logic [W_SEL_LEN-1:0]  w_sel,
  input  logic                  w_wq,
  input  logic [X_ADDR_LEN-1:0] x_addr,
  input  logic [X_SEL_LEN-1:0]  x_sel,
  input  logic                  x_wq,
  input  logic                  wx_write,
  output logic                  w_data,
  output logic                  x_data,
  output logic                  err_wr
);

  localparam int W_BANKS = 1 << W_SEL_LEN;
  localparam int X_BANKS = 1 << X_SEL_LEN;
  localparam int W_IDX   = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
  localparam int X_IDX   = (X_DEPTH > 1) ? $clog2(X_DEPTH) : 1;
  localparam logic [W_ADDR_LEN:0] W_LIMIT = W_DEPTH[W_ADDR_LEN:0];
  localparam logic [X_ADDR_LEN:0] X_LIMIT = X_DEPTH[X_ADDR_LEN:0];

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg, state_next;
  logic   compute_en_reg, compute_en_next;
  logic   err_wr_reg, err_wr_next;
  logic   x_wq_d_reg;

  always_comb begin
    state_next      = state_reg;
    err_wr_next     = err_wr_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (compute_finish) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
    // Each new run starts with a clean error flag; during a run it only ever sets.
    if (state_reg != RUN && state_next == RUN) begin
      err_wr_next = 1'b0;
    end else if (state_reg == RUN && w_wq) begin
      err_wr_next = 1'b1;
    end
    compute_en_next = (state_next == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      compute_en_reg <= 1'b0;
      err_wr_reg     <= 1'b0;
      x_wq_d_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      compute_en_reg <= compute_en_next;
      err_wr_reg     <= err_wr_next;
      x_wq_d_reg     <= x_wq;
    end
  end

  assign busy       = (state_reg == RUN);
  assign done       = (state_reg == DONE);
  assign ld_ready   = (state_reg == IDLE) || (state_reg == DONE);
  assign compute_en = compute_en_reg;
  assign err_wr     = err_wr_reg;

  logic                  ld_fire, eng_wr;
  logic                  w_rd_ok, x_rd_ok, ld_w_ok, ld_x_ok;
  logic [X_ADDR_LEN-1:0] ld_x_addr;
  logic [X_IDX-1:0]      x_wr_idx;
  logic                  x_wr_data;
  logic [W_BANKS-1:0]    w_rd;
  logic [X_BANKS-1:0]    x_rd;

  assign ld_fire   = ld_valid && ld_ready;
  assign eng_wr    = (state_reg == RUN) && x_wq && !x_wq_d_reg && x_rd_ok;
  assign ld_x_addr = ld_addr[X_ADDR_LEN-1:0];
  assign w_rd_ok   = {1'b0, w_addr} < W_LIMIT;
  assign x_rd_ok   = {1'b0, x_addr} < X_LIMIT;
  assign ld_w_ok   = {1'b0, ld_addr} < W_LIMIT;
  assign ld_x_ok   = {1'b0, ld_x_addr} < X_LIMIT;

  // Loads and engine writes never coincide (different states), so one write port suffices.
  assign x_wr_idx  = eng_wr ? x_addr[X_IDX-1:0] : ld_x_addr[X_IDX-1:0];
  assign x_wr_data = eng_wr ? wx_write : ld_data;

  for (genvar gi = 0; gi < W_BANKS; gi++) begin : g_wbank
    logic mem [W_DEPTH];
    logic we;
    assign we = ld_fire && ld_is_w && ld_w_ok && (int'(ld_sel) == gi);
    always_ff @(posedge clk) begin
      if (we) mem[ld_addr[W_IDX-1:0]] <= ld_data;
    end
    assign w_rd[gi] = w_rd_ok && mem[w_addr[W_IDX-1:0]];
  end

  for (genvar gi = 0; gi < X_BANKS; gi++) begin : g_xbank
    logic mem [X_DEPTH];
    logic we;
    assign we = (ld_fire && !ld_is_w && ld_x_ok && (int'(ld_sel) == gi)) ||
                (eng_wr && (int'(x_sel) == gi));
    always_ff @(posedge clk) begin
      if (we) mem[x_wr_idx] <= x_wr_data;
    end
    assign x_rd[gi] = x_rd_ok && mem[x_addr[X_IDX-1:0]];
  end

  assign w_data = w_rd[w_sel];
  assign x_data = x_rd[x_sel];

endmodule

// File: tb/tb_wx_mem_responder.sv
// Self-checking bench for wx_mem_responder in a small configuration (16-word weight
// banks, 4-word activation banks); read data is checked through a scoreboard queue.
module tb_wx_mem_responder;
  localparam int WAL = 20;
  localparam int XAL = 10;
  localparam int WD  = 16;
  localparam int XD  = 4;

  logic           clk = 1'b0;
  logic           rst, start, busy, done;
  logic           ld_valid, ld_ready, ld_is_w, ld_data;
  logic [1:0]     ld_sel;
  logic [WAL-1:0] ld_addr;
  logic           compute_en, compute_finish;
  logic [WAL-1:0] w_addr;
  logic [1:0]     w_sel;
  logic           w_wq;
  logic [XAL-1:0] x_addr;
  logic [1:0]     x_sel;
  logic           x_wq, wx_write, w_data, x_data, err_wr;

  wx_mem_responder #(
    .W_ADDR_LEN(WAL), .X_ADDR_LEN(XAL), .W_SEL_LEN(2), .X_SEL_LEN(2),
    .W_DEPTH(WD), .X_DEPTH(XD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_is_w(ld_is_w), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .compute_en(compute_en),
    .compute_finish(compute_finish), .w_addr(w_addr), .w_sel(w_sel), .w_wq(w_wq),
    .x_addr(x_addr), .x_sel(x_sel), .x_wq(x_wq), .wx_write(wx_write),
    .w_data(w_data), .x_data(x_data), .err_wr(err_wr)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  bit   exp_q[$];
  bit   xm [4][XD];
  bit   wm [4][WD];
  logic [4:0] flags;

  always_comb flags = {busy, done, ld_ready, compute_en, err_wr};

  function automatic bit xm_rd(int s, int a);
    return (a < XD) ? xm[s][a] : 1'b0;
  endfunction

  function automatic bit wm_rd(int s, int a);
    return (a < WD) ? wm[s][a] : 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host load of one word while the port is ready; the model follows the range rule.
  task automatic load(input bit is_w, input int sel, input int addr, input bit d);
    ld_valid = 1'b1; ld_is_w = is_w; ld_sel = sel[1:0]; ld_addr = addr[WAL-1:0]; ld_data = d;
    tick();
    ld_valid = 1'b0;
    if (is_w && addr < WD) wm[sel][addr] = d;
    if (!is_w && (addr % 1024) < XD) xm[sel][addr % 1024] = d;
    $display("load is_w=%0b sel=%0d addr=%0d data=%0b", is_w, sel, addr, d);
  endtask

  task automatic test_reset();
    bit e;
    rst = 1'b1; start = 0; ld_valid = 0; ld_is_w = 0; ld_sel = 0; ld_addr = 0; ld_data = 0;
    compute_finish = 0; w_addr = 0; w_sel = 0; w_wq = 0; x_addr = 0; x_sel = 0;
    x_wq = 0; wx_write = 0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (flags !== 5'b00100) begin
      $display("FAIL reset_flags: got busy/done/ld_ready/en/err=%b expected 00100", flags);
      miscompares++;
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (flags !== 5'b00100) begin
      $display("FAIL idle_flags: got %b expected 00100", flags);
      miscompares++;
    end
    $display("reset done, flags=%b", flags);
  endtask

  task automatic test_preload();
    bit e;
    for (int i = 0; i < 4; i++) load(1'b0, 0, i, (i != 1));
    for (int i = 0; i < 4; i++) load(1'b1, 0, i, (i < 2));
    load(1'b1, 0, 5, 1'b1);
    load(1'b0, 1, 3, 1'b0);
    load(1'b0, 1, 2, 1'b0);
    // Out-of-range loads would alias onto address 0 if the range check were missing.
    load(1'b0, 0, 4, 1'b0);
    load(1'b1, 0, 16, 1'b0);
    for (int i = 0; i < 5; i++) begin
      x_sel = 2'd0; x_addr = i[XAL-1:0]; exp_q.push_back(xm_rd(0, i));
      #1; e = exp_q.pop_front(); vectors++;
      if (x_data !== e) begin
        $display("FAIL preload_x0[%0d]: got %b expected %b", i, x_data, e); miscompares++;
      end
    end
    foreach (wm[0][i]) if (i < 4 || i == 5 || i == 16) begin end
    for (int i = 0; i < 17; i += (i == 5) ? 11 : ((i == 3) ? 2 : 1)) begin
      w_sel = 2'd0; w_addr = i[WAL-1:0]; exp_q.push_back(wm_rd(0, i));
      #1; e = exp_q.pop_front(); vectors++;
      if (w_data !== e) begin
        $display("FAIL preload_w0[%0d]: got %b expected %b", i, w_data, e); miscompares++;
      end
    end
  endtask

  task automatic test_run_and_engine_write();
    bit e;
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (flags !== 5'b10010) begin
      $display("FAIL run_entry: got %b expected 10010", flags); miscompares++;
    end
    ld_valid = 1'b1; ld_is_w = 0; ld_sel = 0; ld_addr = 0; ld_data = 0;
    tick(); tick();
    vectors++;
    if (ld_ready !== 1'b0) begin
      $display("FAIL ld_ready_run: got %b expected 0", ld_ready); miscompares++;
    end
    ld_valid = 1'b0;
    x_sel = 2'd0; x_addr = 0; exp_q.push_back(xm_rd(0, 0));
    #1; e = exp_q.pop_front(); vectors++;
    if (x_data !== e) begin
      $display("FAIL run_load_dropped: got %b expected %b", x_data, e); miscompares++;
    end
    // Engine write: old value visible before the edge, new one after it, one write only.
    x_sel = 2'd1; x_addr = 3; wx_write = 1'b1; x_wq = 1'b1;
    exp_q.push_back(xm_rd(1, 3));
    #1; e = exp_q.pop_front(); vectors++;
    if (x_data !== e) begin
      $display("FAIL eng_wr_before: got %b expected %b", x_data, e); miscompares++;
    end
    xm[1][3] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(xm_rd(1, 3));
      tick();
      wx_write = 1'b0;
      e = exp_q.pop_front(); vectors++;
      if (x_data !== e) begin
        $display("FAIL eng_wr_hold_c%0d: got %b expected %b", c, x_data, e); miscompares++;
      end
    end
    x_wq = 1'b0;
    $display("engine write x1[3] done");
    compute_finish = 1'b1; start = 1'b1;
    tick();
    compute_finish = 1'b0; start = 1'b0;
    vectors++;
    if (flags !== 5'b01100) begin
      $display("FAIL finish_to_done: got %b expected 01100", flags); miscompares++;
    end
    tick();
    vectors++;
    if (flags !== 5'b01100) begin
      $display("FAIL done_hold: got %b expected 01100", flags); miscompares++;
    end
  endtask

  task automatic test_err_wr();
    bit e;
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (flags !== 5'b10010) begin
      $display("FAIL rerun_entry: got %b expected 10010", flags); miscompares++;
    end
    w_sel = 2'd0; w_addr = 5; w_wq = 1'b1;
    tick();
    w_wq = 1'b0;
    vectors++;
    if (err_wr !== 1'b1) begin
      $display("FAIL err_wr_set: got %b expected 1", err_wr); miscompares++;
    end
    exp_q.push_back(wm_rd(0, 5));
    e = exp_q.pop_front(); vectors++;
    if (w_data !== e) begin
      $display("FAIL w_wq_no_write: got %b expected %b", w_data, e); miscompares++;
    end
    compute_finish = 1'b1; tick(); compute_finish = 1'b0;
    vectors++;
    if (flags !== 5'b01101) begin
      $display("FAIL err_sticky_done: got %b expected 01101", flags); miscompares++;
    end
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (flags !== 5'b10010) begin
      $display("FAIL err_clear_on_run: got %b expected 10010", flags); miscompares++;
    end
    $display("err_wr sequence done");
  endtask

  task automatic test_rst_mid_run();
    bit e;
    x_sel = 2'd1; x_addr = 2; wx_write = 1'b1; x_wq = 1'b0;
    tick();
    rst = 1'b1; x_wq = 1'b1;
    #1;
    vectors++;
    if (flags !== 5'b00100) begin
      $display("FAIL rst_async: got %b expected 00100", flags); miscompares++;
    end
    @(posedge clk); #1; rst = 1'b0;
    tick(); tick();
    x_wq = 1'b0;
    vectors++;
    if (flags !== 5'b00100) begin
      $display("FAIL rst_idle: got %b expected 00100", flags); miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      x_sel = 2'd1; x_addr = i[XAL-1:0]; exp_q.push_back(xm_rd(1, i));
      w_sel = 2'd0; w_addr = i[WAL-1:0]; exp_q.push_back(wm_rd(0, i));
      #1;
      e = exp_q.pop_front(); vectors++;
      if (x_data !== e) begin
        $display("FAIL rst_keep_x1[%0d]: got %b expected %b", i, x_data, e); miscompares++;
      end
      e = exp_q.pop_front(); vectors++;
      if (w_data !== e) begin
        $display("FAIL rst_keep_w0[%0d]: got %b expected %b", i, w_data, e); miscompares++;
      end
    end
    $display("mid-run reset done");
  endtask

  task automatic test_back_to_back();
    bit e;
    bit d;
    for (int i = 0; i < 4; i++) begin
      d = 1'($urandom_range(0, 1));
      ld_valid = 1'b1; ld_is_w = 1'b0; ld_sel = 2'd2; ld_addr = i[WAL-1:0]; ld_data = d;
      xm[2][i] = d;
      tick();
      $display("b2b load x2[%0d]=%0b", i, d);
    end
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x_sel = 2'd2; x_addr = i[XAL-1:0]; exp_q.push_back(xm_rd(2, i));
      #1; e = exp_q.pop_front(); vectors++;
      if (x_data !== e) begin
        $display("FAIL b2b_x2[%0d]: got %b expected %b", i, x_data, e); miscompares++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_run_and_engine_write();
    test_err_wr();
    test_rst_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
